// File: rtl/noc_pkg.sv
// Shared constants, header layout helpers and X-first route decode for the mesh router.
package noc_pkg;

  localparam int NPORTS = 5;
  localparam logic [2:0] P_PE = 3'd0;
  localparam logic [2:0] P_N  = 3'd1;
  localparam logic [2:0] P_S  = 3'd2;
  localparam logic [2:0] P_E  = 3'd3;
  localparam logic [2:0] P_W  = 3'd4;

  // Widest flit the decode function can handle.
  localparam int MAXW = 256;

  typedef enum logic {X_EAST = 1'b0, X_WEST = 1'b1} xdir_e;
  typedef enum logic {Y_NORTH = 1'b0, Y_SOUTH = 1'b1} ydir_e;

  typedef struct packed {
    logic [2:0]      port;
    logic [MAXW-1:0] flit;
  } route_t;

  function automatic int xdir_bit(input int w);
    return w - 1;
  endfunction

  function automatic int ydir_bit(input int w);
    return w - 2;
  endfunction

  function automatic int xhop_lo(input int w, input int xh);
    return w - 2 - xh;
  endfunction

  function automatic int yhop_lo(input int w, input int xh, input int yh);
    return w - 2 - xh - yh;
  endfunction

  function automatic route_t route_decode(input logic [MAXW-1:0] flit, input int w,
                                          input int xh, input int yh);
    route_t r;
    int     x_hi, x_lo, y_hi, y_lo;
    logic   has_x, has_y;
    x_hi  = w - 3;
    x_lo  = xhop_lo(w, xh);
    y_hi  = x_lo - 1;
    y_lo  = yhop_lo(w, xh, yh);
    has_x = 1'b0;
    has_y = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      if (i >= x_lo && i <= x_hi) has_x = has_x | flit[i];
      if (i >= y_lo && i <= y_hi) has_y = has_y | flit[i];
    end
    r.flit = flit;
    r.port = P_PE;
    // Consuming a hop shifts the thermometer field left within its own bits.
    if (has_x) begin
      r.port = (flit[xdir_bit(w)] == X_WEST) ? P_W : P_E;
      for (int i = 0; i < MAXW; i++) begin
        if (i > x_lo && i <= x_hi) r.flit[i] = flit[(i == 0) ? 0 : i - 1];
        else if (i == x_lo) r.flit[i] = 1'b0;
      end
    end else if (has_y) begin
      r.port = (flit[ydir_bit(w)] == Y_SOUTH) ? P_S : P_N;
      for (int i = 0; i < MAXW; i++) begin
        if (i > y_lo && i <= y_hi) r.flit[i] = flit[(i == 0) ? 0 : i - 1];
        else if (i == y_lo) r.flit[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_router_sync_if.sv
// Five-port flit bus: per-port input and output valid/ready channels plus the U-turn flag.
interface noc_router_sync_if
  import noc_pkg::*;
#(
  parameter int WIDTH = 53
);
  logic [NPORTS-1:0]            in_valid;
  logic [NPORTS-1:0]            in_ready;
  logic [NPORTS-1:0][WIDTH-1:0] in_data;
  logic [NPORTS-1:0]            out_valid;
  logic [NPORTS-1:0]            out_ready;
  logic [NPORTS-1:0][WIDTH-1:0] out_data;
  logic                         err_uturn;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, err_uturn);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, err_uturn);
endinterface

// File: rtl/noc_fifo.sv
// Synchronous input FIFO; full comes from the registered count, so no push is taken when full.
module noc_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/noc_router_sync.sv
// Five-port mesh router: per-input FIFO, X-first routing, per-output round-robin arbiter
// and registered output stage with valid/ready backpressure.
module noc_router_sync
  import noc_pkg::*;
#(
  parameter int WIDTH = 53,
  parameter int DEPTH = 4,
  parameter int XH    = 3,
  parameter int YH    = 3
) (
  input logic               clk,
  input logic               rst,
  noc_router_sync_if.slave  bus
);
  logic [NPORTS-1:0][WIDTH-1:0] head_data, new_flit, out_data_q, out_data_d;
  logic [NPORTS-1:0][2:0]       head_port, rr_q, rr_d, gnt_idx;
  logic [NPORTS-1:0]            fifo_empty, fifo_full, head_vld, uturn, pop;
  logic [NPORTS-1:0]            out_valid_q, out_valid_d, gnt_vld, out_free;
  logic                         err_q, err_d;
  logic                         unused_route_bits;
  route_t                       rt [NPORTS];

  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    noc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.in_valid[p]),
      .data_i  (bus.in_data[p]),
      .pop_i   (pop[p]),
      .data_o  (head_data[p]),
      .empty_o (fifo_empty[p]),
      .full_o  (fifo_full[p])
    );
  end

  always_comb begin
    head_port         = '0;
    new_flit          = '0;
    head_vld          = '0;
    uturn             = '0;
    unused_route_bits = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      rt[p]             = route_decode(MAXW'(head_data[p]), WIDTH, XH, YH);
      head_port[p]      = rt[p].port;
      new_flit[p]       = rt[p].flit[WIDTH-1:0];
      head_vld[p]       = ~fifo_empty[p];
      uturn[p]          = head_vld[p] && (rt[p].port == 3'(p)) && (3'(p) != P_PE);
      unused_route_bits = unused_route_bits ^ (^rt[p].flit[MAXW-1:WIDTH]);
    end
  end

  // Reverse scan so the candidate closest to rr wins the last assignment.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_vld     = '0;
    gnt_idx     = '0;
    out_free    = '0;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int o = 0; o < NPORTS; o++) begin
      out_free[o] = ~out_valid_q[o] | bus.out_ready[o];
      for (int k = NPORTS - 1; k >= 0; k--) begin
        idx = int'(rr_q[o]) + k;
        if (idx >= NPORTS) idx = idx - NPORTS;
        if (head_vld[idx] && !uturn[idx] && head_port[idx] == 3'(o)) begin
          gnt_vld[o] = out_free[o];
          gnt_idx[o] = 3'(idx);
        end
      end
      if (gnt_vld[o]) begin
        out_valid_d[o] = 1'b1;
        out_data_d[o]  = new_flit[gnt_idx[o]];
        rr_d[o]        = (gnt_idx[o] == 3'(NPORTS - 1)) ? 3'd0 : gnt_idx[o] + 3'd1;
      end else if (bus.out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
  end

  always_comb begin
    pop = uturn;
    for (int o = 0; o < NPORTS; o++) begin
      if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
    end
    err_d = err_q | (|uturn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      rr_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = ~fifo_full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err_uturn = err_q;
endmodule
